// File: rtl/player_rx_decoder.sv
// UART 8N1 receiver that decodes one-byte player control frames into lane/firing/projectile/reset state.
// Optional build macro PLAYER_RX_GLITCH_FILTER_EN: each bit is the 2-of-3 majority of ticks 7, 8 and 9.
module player_rx_decoder #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] lane,
  output logic       proj_type,
  output logic       firing,
  output logic       fire_pulse,
  output logic       game_reset,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int DIV   = (CLK_FREQ / (BAUD * 16) > 0) ? CLK_FREQ / (BAUD * 16) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_DECODE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               wait_high_q, wait_high_d;
  logic [3:0]         lane_q, lane_d;
  logic               firing_q, firing_d;
  logic               proj_q, proj_d;
  logic               game_reset_q, game_reset_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               fire_pulse_q, fire_pulse_d;
  logic               tick_s;
  logic               sample_s;
  logic               bit_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Bit 6 must be zero and lane nibble must be 0..9 for the frame to be usable.
  function automatic logic frame_ok(input logic [7:0] b);
    return (b[6] == 1'b0) && (b[3:0] <= 4'd9);
  endfunction

  assign tick_s = (div_cnt_q == DIV_W'(DIV - 1));

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef PLAYER_RX_GLITCH_FILTER_EN
  logic samp7_q, samp7_d;
  logic samp8_q, samp8_d;

  // Capture tick 7 and tick 8 samples; the vote is taken on tick 9.
  always_comb begin
    samp7_d  = samp7_q;
    samp8_d  = samp8_q;
    if (tick_s && (tick_cnt_q == 4'd6)) begin
      samp7_d = rx_sync_q;
    end else begin
      samp7_d = samp7_q;
    end
    if (tick_s && (tick_cnt_q == 4'd7)) begin
      samp8_d = rx_sync_q;
    end else begin
      samp8_d = samp8_q;
    end
    sample_s = tick_s && (tick_cnt_q == 4'd8);
    bit_s    = maj3(samp7_q, samp8_q, rx_sync_q);
  end

  // Majority-vote sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp7_q <= 1'b1;
      samp8_q <= 1'b1;
    end else begin
      samp7_q <= samp7_d;
      samp8_q <= samp8_d;
    end
  end
`else
  // Single bit-centre sample on tick 8.
  always_comb begin
    sample_s = tick_s && (tick_cnt_q == 4'd7);
    bit_s    = rx_sync_q;
  end
`endif

  // Next-state, bit assembly and frame decode.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = tick_s ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1);
    tick_cnt_d    = tick_s ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    wait_high_d   = wait_high_q;
    lane_d        = lane_q;
    firing_d      = firing_q;
    proj_d        = proj_q;
    game_reset_d  = game_reset_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    fire_pulse_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Level check (not edge) so a start arriving during DECODE is still seen here.
        if (!rx_sync_q) begin
          state_d    = S_START;
          div_cnt_d  = {DIV_W{1'b0}};
          tick_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (sample_s) begin
          if (!bit_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end

      S_DATA: begin
        if (sample_s) begin
          shift_d = {bit_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_STOP: begin
        if (wait_high_q) begin
          if (rx_sync_q) begin
            wait_high_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_STOP;
          end
        end else if (sample_s) begin
          if (bit_s && frame_ok(shift_q)) begin
            state_d       = S_DECODE;
            lane_d        = (shift_q[3:0] == 4'd0) ? 4'd5 : shift_q[3:0];
            firing_d      = shift_q[5];
            proj_d        = shift_q[4];
            game_reset_d  = shift_q[7];
            frame_valid_d = 1'b1;
            fire_pulse_d  = shift_q[5] & ~firing_q;
          end else if (bit_s) begin
            state_d     = S_DECODE;
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end

      S_DECODE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        wait_high_d = 1'b0;
      end
    endcase
  end

  // FSM, timing counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= {DIV_W{1'b0}};
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      wait_high_q   <= 1'b0;
      lane_q        <= 4'd5;
      firing_q      <= 1'b0;
      proj_q        <= 1'b0;
      game_reset_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      fire_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      wait_high_q   <= wait_high_d;
      lane_q        <= lane_d;
      firing_q      <= firing_d;
      proj_q        <= proj_d;
      game_reset_q  <= game_reset_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      fire_pulse_q  <= fire_pulse_d;
    end
  end

  assign lane        = lane_q;
  assign firing      = firing_q;
  assign proj_type   = proj_q;
  assign game_reset  = game_reset_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign fire_pulse  = fire_pulse_q;

endmodule

// File: doc/player_rx_decoder.md
PLAYER_RX_DECODER -- requirements
Module: player_rx_decoder

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, UART bit rate.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 rx  input  1  UART serial line, idle high, 8N1, LSB first.
REQ-006 lane  output  4  last accepted player lane, 1..9.
REQ-007 proj_type  output  1  last accepted projectile type bit.
REQ-008 firing  output  1  last accepted is_firing level.
REQ-009 fire_pulse  output  1  one-cycle strobe on 0->1 transition of accepted firing bit.
REQ-010 game_reset  output  1  level; high while last accepted frame carried reset bit = 1.
REQ-011 frame_valid  output  1  one-cycle strobe when a frame is accepted.
REQ-012 frame_err  output  1  one-cycle strobe when a frame is rejected.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer (preset to 1 on reset) before any use.
REQ-014 Oversample tick SHALL be generated every DIV = CLK_FREQ/(BAUD*16) (integer floor) clocks via a free-running counter restarted on start-edge detection.
REQ-015 RX FSM states: IDLE, START, DATA, STOP, DECODE.
REQ-016 IDLE -> START on synchronized rx falling to 0; counter restarted.
REQ-017 START: at tick 8 (bit centre) rx = 0 -> DATA; rx = 1 -> IDLE, no strobe (false start).
REQ-018 DATA: sample every 16 ticks at bit centre, 8 bits, LSB first into shift register -> STOP.
REQ-019 STOP: sample at bit centre; 1 -> DECODE; 0 -> frame_err strobe, wait for rx = 1, then IDLE.
REQ-020 DECODE (one cycle): byte b = {reset, zero, firing, proj, lane[3:0]}; reject (frame_err) if b[6] = 1 or b[3:0] > 9.
REQ-021 Accept: b[3:0] = 0 (reset state) -> lane SHALL load 5; 1..9 -> lane loads b[3:0]; firing<=b[5], proj_type<=b[4], game_reset<=b[7]; frame_valid strobe.
REQ-022 fire_pulse SHALL assert in the same cycle as frame_valid iff new firing = 1 and previous accepted firing = 0.
REQ-023 Rejected frames SHALL leave lane, firing, proj_type, game_reset unchanged.
REQ-024 Latency: outputs update one clk after the stop-bit centre sample; DECODE -> IDLE unconditionally.
REQ-025 Start edge arriving during DECODE SHALL be detected in IDLE the next cycle (no frame lost for back-to-back bytes).
REQ-026 frame_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-027 rst low SHALL immediately force: FSM IDLE, counters 0, lane = 5, firing = 0, proj_type = 0, game_reset = 0, all strobes 0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame; after release, decoding resumes at next start edge only.

Configuration
REQ-029 Macro PLAYER_RX_GLITCH_FILTER_EN defined: each bit (start, data, stop) SHALL be the 2-of-3 majority of samples at ticks 7, 8, 9.
REQ-030 Macro undefined: single sample at tick 8; no extra registers instantiated.

Verification (CLK_FREQ = 100000000, BAUD = 9600, DIV = 651, bit = 10416 clk)
REQ-031 rst low then high, rx idle -> lane = 5, firing = 0, proj_type = 0, game_reset = 0, no strobes.
REQ-032 Send 0x37 -> frame_valid once, lane = 7, firing = 1, proj_type = 1, fire_pulse once; then 0x33 -> firing = 1, no fire_pulse.
REQ-033 Send 0x4A, then 0x0C -> two frame_err strobes, outputs unchanged from prior values.
REQ-034 Stop bit driven 0 on 0x05 -> frame_err, lane unchanged; line returned high -> next 0x02 accepted, lane = 2.
REQ-035 rx low pulse of 3000 clk then high -> no strobe, FSM back in IDLE; 0x80 -> game_reset = 1, lane = 5.
REQ-036 rst low during DATA bit 4 of 0x09 -> no strobe, lane = 5; with PLAYER_RX_GLITCH_FILTER_EN, one-clk low glitch at tick 8 of data bit -> byte decoded correctly.
